// File: rtl/ram_byte_packer.sv
// ram_byte_packer: reads a frame of NUM_BITS single-bit RAM locations, packs
// them LSB-first into bytes and hands each byte to a UART transmitter.
//
// Handshakes:
//   ram_addr/ram_q : ram_q returns RAM[ram_addr] one cycle after the address
//                    is presented (registered-address RAM).
//   tx_start/tx_rdy: tx_start pulses for one cycle only while tx_rdy is high;
//                    tx_data is held stable from that pulse until the next
//                    byte is loaded. The transmitter may take a cycle to drop
//                    tx_rdy, so tx_rdy is ignored in the cycle after tx_start.
//   start/busy/done: start is accepted only in IDLE; busy covers the frame and
//                    done pulses once, with busy already low, after the last
//                    byte has been sent.
module ram_byte_packer #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_q,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int NUM_BYTES = (NUM_BITS + 7) / 8;
    localparam int CNT_W     = $clog2(NUM_BITS + 1);
    localparam int BYTE_W    = $clog2(NUM_BYTES + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0]  BITS_TOTAL  = CNT_W'(NUM_BITS);
    localparam logic [BYTE_W-1:0] BYTES_TOTAL = BYTE_W'(NUM_BYTES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        SEND    = 3'd2,
        WAIT_TX = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;     // bits issued so far in this frame
    logic [3:0]        issue_idx;   // bits issued so far in this byte
    logic              cap_vld;     // ram_q holds data for an issued address
    logic [2:0]        cap_pos;     // bit position that ram_q belongs to
    logic [7:0]        shift_reg;   // byte being assembled
    logic [BYTE_W-1:0] byte_cnt;    // bytes launched so far
    logic              wait_first;  // first cycle of WAIT_TX
    logic              armed;       // low for the first clock after reset

    logic              can_issue;
    logic [7:0]        byte_next;

    assign state_dbg = state;

    // Decide whether another address goes out and merge the bit arriving now.
    always_comb begin
        can_issue = (issue_idx < 4'd8) && (bit_cnt < BITS_TOTAL);
        byte_next = shift_reg;
        if (cap_vld) begin
            byte_next[cap_pos] = ram_q;
        end
    end

    // Blocks a start that coincides with the release of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Frame sequencer: read 8 bits, send the byte, repeat until the frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ram_addr   <= '0;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_cnt    <= '0;
            issue_idx  <= '0;
            cap_vld    <= 1'b0;
            cap_pos    <= '0;
            shift_reg  <= '0;
            byte_cnt   <= '0;
            wait_first <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && armed) begin
                        state     <= READ;
                        ram_addr  <= '0;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        issue_idx <= '0;
                        cap_vld   <= 1'b0;
                        shift_reg <= '0;
                        busy      <= 1'b1;
                    end
                end
                READ: begin
                    shift_reg <= byte_next;
                    cap_vld   <= can_issue;
                    cap_pos   <= issue_idx[2:0];
                    if (can_issue) begin
                        issue_idx <= issue_idx + 4'd1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (ram_addr != LAST_ADDR) begin
                            ram_addr <= ram_addr + 1'b1;
                        end
                    end else if (cap_vld) begin
                        tx_data <= byte_next;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_rdy) begin
                        tx_start   <= 1'b1;
                        byte_cnt   <= byte_cnt + 1'b1;
                        wait_first <= 1'b1;
                        state      <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (tx_rdy) begin
                        if (byte_cnt == BYTES_TOTAL) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= READ;
                            issue_idx <= '0;
                            cap_vld   <= 1'b0;
                            shift_reg <= '0;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_byte_packer.sv
// Bench for ram_byte_packer: a full-size instance (784 bits) and a short
// 12-bit instance, each with a registered-address RAM model and a UART model.
module tb_ram_byte_packer;

    localparam int NB      = 784;
    localparam int NBY     = 98;
    localparam int TX_BUSY = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, ram_q, tx_start, tx_rdy, busy, done;
    logic [9:0] ram_addr;
    logic [7:0] tx_data;
    logic [2:0] state_dbg;

    logic       start_s, ram_q_s, tx_start_s, tx_rdy_s, busy_s, done_s;
    logic [3:0] ram_addr_s;
    logic [7:0] tx_data_s;
    logic [2:0] state_dbg_s;

    ram_byte_packer #(.NUM_BITS(NB), .ADDR_W(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ram_addr(ram_addr),
        .ram_q(ram_q), .tx_data(tx_data), .tx_start(tx_start), .tx_rdy(tx_rdy),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    ram_byte_packer #(.NUM_BITS(12), .ADDR_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .ram_addr(ram_addr_s),
        .ram_q(ram_q_s), .tx_data(tx_data_s), .tx_start(tx_start_s), .tx_rdy(tx_rdy_s),
        .busy(busy_s), .done(done_s), .state_dbg(state_dbg_s)
    );

    int checks;
    int errors;

    // ---------------- RAM and UART models ----------------
    logic mem   [0:1023];
    logic mem_s [0:15];
    int   tx_busy_cnt, tx_busy_cnt_s;
    logic tx_hold;

    always @(posedge clk) ram_q   <= mem[ram_addr];
    always @(posedge clk) ram_q_s <= mem_s[ram_addr_s];

    always @(posedge clk) begin
        if (tx_start) tx_busy_cnt <= TX_BUSY;
        else if (tx_busy_cnt != 0) tx_busy_cnt <= tx_busy_cnt - 1;
        if (tx_start_s) tx_busy_cnt_s <= 3;
        else if (tx_busy_cnt_s != 0) tx_busy_cnt_s <= tx_busy_cnt_s - 1;
    end

    assign tx_rdy   = (tx_busy_cnt == 0) && !tx_hold;
    assign tx_rdy_s = (tx_busy_cnt_s == 0);

    // ---------------- scoreboard / monitors ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_s_q[$];
    int   tx_cnt, done_cnt, overlap_cnt, addr_err, addr_steps, max_addr;
    int   tx_cnt_s, done_cnt_s, max_addr_s;
    logic was_busy;
    logic [9:0] last_addr;

    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_start) begin
            tx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_data_extra: got byte %h, expected no more bytes", tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_data: byte %0d got %h expected %h", tx_cnt - 1, tx_data, e);
                end
            end
        end
        if (done) done_cnt++;
        if (tx_start && done) overlap_cnt++;
        if (busy) begin
            if (!was_busy) begin
                if (ram_addr != 10'd0) addr_err++;
            end else if (ram_addr != last_addr) begin
                if (ram_addr != last_addr + 10'd1) addr_err++;
                addr_steps++;
            end
            last_addr = ram_addr;
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            if (int'(ram_addr) > NB - 1) addr_err++;
        end
        was_busy = busy;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_start_s) begin
            tx_cnt_s++;
            checks++;
            if (exp_s_q.size() == 0) begin
                errors++;
                $display("FAIL small_tx_extra: got byte %h, expected no more bytes", tx_data_s);
            end else begin
                e = exp_s_q.pop_front();
                if (tx_data_s !== e) begin
                    errors++;
                    $display("FAIL small_tx_data: got %h expected %h", tx_data_s, e);
                end
            end
        end
        if (done_s) done_cnt_s++;
        if (int'(ram_addr_s) > max_addr_s) max_addr_s = int'(ram_addr_s);
    end

    // ---------------- driver helpers ----------------
    function automatic void push_exp();
        logic [7:0] b;
        for (int k = 0; k < NBY; k++) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (8 * k + i < NB) b[i] = mem[8 * k + i];
            end
            exp_q.push_back(b);
        end
    endfunction

    task automatic clear_stats();
        tx_cnt = 0; done_cnt = 0; overlap_cnt = 0;
        addr_err = 0; addr_steps = 0; max_addr = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int c = 0; c < n; c++) @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wait_cycles(3);
        checks += 6;
        if (ram_addr !== 10'd0) begin errors++; $display("FAIL rst_ram_addr: got %0d expected 0", ram_addr); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
        // start in the cycle reset is released is ignored
        @(posedge clk); #1 rst_n = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_cycles(2);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_start_busy: got %b expected 0", busy); end
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_release_start_state: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < 1024; i++) mem[i] = 1'b1;
        clear_stats();
        push_exp();
        pulse_start();
        for (int c = 0; c < 8000 && done_cnt == 0; c++) @(posedge clk);
        wait_cycles(20);
        checks += 5;
        if (done_cnt != 1) begin errors++; $display("FAIL ones_done: got %0d expected 1", done_cnt); end
        if (tx_cnt != NBY) begin errors++; $display("FAIL ones_tx_count: got %0d expected %0d", tx_cnt, NBY); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL ones_left: got %0d expected 0", exp_q.size()); end
        if (overlap_cnt != 0) begin errors++; $display("FAIL ones_overlap: got %0d expected 0", overlap_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ones_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_lsb_first();
        for (int i = 0; i < 1024; i++) mem[i] = ((i % 8) == 0);
        clear_stats();
        push_exp();
        pulse_start();
        for (int c = 0; c < 8000 && done_cnt == 0; c++) @(posedge clk);
        wait_cycles(5);
        checks += 6;
        if (done_cnt != 1) begin errors++; $display("FAIL lsb_done: got %0d expected 1", done_cnt); end
        if (tx_cnt != NBY) begin errors++; $display("FAIL lsb_tx_count: got %0d expected %0d", tx_cnt, NBY); end
        if (addr_err != 0) begin errors++; $display("FAIL lsb_addr_seq: got %0d bad steps expected 0", addr_err); end
        if (addr_steps != NB - 1) begin errors++; $display("FAIL lsb_addr_steps: got %0d expected %0d", addr_steps, NB - 1); end
        if (max_addr != NB - 1) begin errors++; $display("FAIL lsb_addr_max: got %0d expected %0d", max_addr, NB - 1); end
        if (ram_addr !== 10'(NB - 1)) begin errors++; $display("FAIL lsb_addr_hold: got %0d expected %0d", ram_addr, NB - 1); end
    endtask

    task automatic test_small();
        for (int i = 0; i < 16; i++) mem_s[i] = 1'b1;
        tx_cnt_s = 0; done_cnt_s = 0; max_addr_s = 0;
        exp_s_q.push_back(8'hFF);
        exp_s_q.push_back(8'h0F);
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        for (int c = 0; c < 500 && done_cnt_s == 0; c++) @(posedge clk);
        wait_cycles(5);
        checks += 4;
        if (tx_cnt_s != 2) begin errors++; $display("FAIL small_tx_count: got %0d expected 2", tx_cnt_s); end
        if (done_cnt_s != 1) begin errors++; $display("FAIL small_done: got %0d expected 1", done_cnt_s); end
        if (max_addr_s != 11) begin errors++; $display("FAIL small_addr_max: got %0d expected 11", max_addr_s); end
        if (exp_s_q.size() != 0) begin errors++; $display("FAIL small_left: got %0d expected 0", exp_s_q.size()); end
    endtask

    task automatic test_tx_hold();
        int held_pulses;
        int data_bad;
        logic [7:0] first;
        for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom_range(0, 1));
        clear_stats();
        push_exp();
        first = exp_q[0];
        tx_hold = 1'b1;
        pulse_start();
        wait_cycles(15);
        held_pulses = 0;
        data_bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (tx_start) held_pulses++;
            if (tx_data !== first) data_bad++;
        end
        checks += 3;
        if (held_pulses != 0) begin errors++; $display("FAIL hold_no_pulse: got %0d pulses expected 0", held_pulses); end
        if (data_bad != 0) begin errors++; $display("FAIL hold_data_stable: got %0d bad cycles expected 0", data_bad); end
        if (state_dbg !== 3'd2) begin errors++; $display("FAIL hold_state: got %0d expected 2", state_dbg); end
        tx_hold = 1'b0;
        wait_cycles(3);
        checks++;
        if (tx_cnt != 1) begin errors++; $display("FAIL hold_single_pulse: got %0d expected 1", tx_cnt); end
        for (int c = 0; c < 8000 && done_cnt == 0; c++) @(posedge clk);
        wait_cycles(5);
        checks += 2;
        if (tx_cnt != NBY) begin errors++; $display("FAIL hold_tx_count: got %0d expected %0d", tx_cnt, NBY); end
        if (done_cnt != 1) begin errors++; $display("FAIL hold_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom_range(0, 1));
        clear_stats();
        push_exp();
        pulse_start();
        for (int c = 0; c < 2000 && tx_cnt < 3; c++) @(posedge clk);
        wait_cycles(2);
        checks++;
        if (tx_cnt != 3) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", tx_cnt); end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (ram_addr !== 10'd0) begin errors++; $display("FAIL mid_rst_addr: got %0d expected 0", ram_addr); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", tx_data); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_start: got %b expected 0", tx_start); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b expected 0", done); end
        exp_q.delete();
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(200);
        checks += 2;
        if (tx_cnt != 3) begin errors++; $display("FAIL mid_no_more_tx: got %0d expected 3", tx_cnt); end
        if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt); end
        // fresh frame after the abort
        for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom_range(0, 1));
        clear_stats();
        push_exp();
        pulse_start();
        for (int c = 0; c < 8000 && done_cnt == 0; c++) @(posedge clk);
        wait_cycles(5);
        checks += 3;
        if (tx_cnt != NBY) begin errors++; $display("FAIL mid_restart_count: got %0d expected %0d", tx_cnt, NBY); end
        if (done_cnt != 1) begin errors++; $display("FAIL mid_restart_done: got %0d expected 1", done_cnt); end
        if (addr_err != 0) begin errors++; $display("FAIL mid_restart_addr: got %0d bad steps expected 0", addr_err); end
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom_range(0, 1));
        clear_stats();
        push_exp();
        pulse_start();
        wait_cycles($urandom_range(100, 400));
        pulse_start();
        for (int c = 0; c < 8000 && done_cnt == 0; c++) @(posedge clk);
        wait_cycles(300);
        checks += 4;
        if (tx_cnt != NBY) begin errors++; $display("FAIL busy_start_count: got %0d expected %0d", tx_cnt, NBY); end
        if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL busy_start_left: got %0d expected 0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; start_s = 1'b0; tx_hold = 1'b0;
        tx_busy_cnt = 0; tx_busy_cnt_s = 0;
        was_busy = 1'b0; last_addr = '0;
        tx_cnt_s = 0; done_cnt_s = 0; max_addr_s = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
        for (int i = 0; i < 16; i++) mem_s[i] = 1'b0;
        clear_stats();

        test_reset();
        test_all_ones();
        test_lsb_first();
        test_small();
        test_tx_hold();
        test_reset_mid();
        test_start_while_busy();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_byte_packer.md
RAM_BYTE_PACKER -- requirements
Module: ram_byte_packer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 784, number of 1-bit RAM locations read back per frame.
REQ-002 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to read back a full frame.
REQ-006 SHALL have port ram_addr  output  ADDR_W  read address to 1-bit RAM.
REQ-007 SHALL have port ram_q  input  1  RAM read data, valid the cycle after ram_addr is presented (registered-address RAM).
REQ-008 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-009 SHALL have port tx_start  output  1  one-cycle pulse launching transmission of tx_data.
REQ-010 SHALL have port tx_rdy  input  1  transmitter idle/ready.
REQ-011 SHALL have port busy  output  1  high from accepted start until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last byte is fully sent.

Function
REQ-013 SHALL implement FSM states IDLE, READ, SEND, WAIT_TX, FINISH.
REQ-014 IDLE: start=1 -> READ, ram_addr=0, bit index=0, byte count=0, busy=1; start ignored when not in IDLE.
REQ-015 READ: SHALL issue one address per cycle (ram_addr increments by 1), capturing ram_q one cycle later into bit position = index of the address issued; 8 bits collected in 9 cycles.
REQ-016 Bit order SHALL be LSB-first: byte k bit i = RAM[8k+i].
REQ-017 When frame has < 8 remaining bits, SHALL stop issuing addresses at NUM_BITS-1 and zero-fill unused upper bits.
REQ-018 ram_addr SHALL never exceed NUM_BITS-1; after the last issue it SHALL hold its value.
REQ-019 After the 8th (or last) capture -> SEND; packed byte SHALL be loaded to tx_data, which stays stable until the next byte is loaded.
REQ-020 SEND: SHALL wait for tx_rdy=1, then assert tx_start for exactly one cycle and go to WAIT_TX.
REQ-021 WAIT_TX: SHALL ignore tx_rdy in the first cycle, then wait for tx_rdy=1; then -> READ if bytes remain, else FINISH.
REQ-022 Byte count SHALL equal ceil(NUM_BITS/8) (98 at default); exactly that many tx_start pulses per frame.
REQ-023 FINISH: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
REQ-024 tx_start and done SHALL never be asserted in the same cycle.
REQ-025 READ of the next byte SHALL NOT begin before the previous byte's tx_start has been issued (no overlap of read and send).

Reset
REQ-026 On rst_n=0, SHALL asynchronously enter IDLE with ram_addr=0, tx_data=0x00, tx_start=0, busy=0, done=0, counters=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no further tx_start; after release the block SHALL wait for a new start.
REQ-028 start asserted in the same cycle reset is released SHALL be ignored.

Verification
REQ-029 RAM all ones, NUM_BITS=784, tx_rdy model busy 10 cycles per byte, pulse start -> 98 tx_start pulses, every tx_data=0xFF, one done pulse.
REQ-030 RAM[8k+i]=(i==0), pulse start -> every byte 0x01 (LSB-first check); ram_addr sequence 0..783 monotonic, each address issued exactly once.
REQ-031 NUM_BITS=12, RAM[0..11]=1 -> two bytes 0xFF then 0x0F; ram_addr never >11.
REQ-032 tx_rdy held low 50 cycles during SEND -> tx_start held off, tx_data stable, then single pulse when tx_rdy rises.
REQ-033 Reset asserted after 3rd byte sent -> no further tx_start or done; outputs at reset values; new start reads from address 0.
REQ-034 Second start pulsed while busy -> ignored, exactly 98 bytes and one done.
